probabilistic_search_engine: RTL
================================

PROBABILISTIC_SEARCH_ENGINE -- requirements
Module: probabilistic_search_engine

Interface
REQ-001 SHALL have parameter NUM_BOOL, default 8: number of boolean variables (>=1).
REQ-002 SHALL have parameter NUM_INT, default 4: number of integer variables (>=1).
REQ-003 SHALL have parameter INT_W, default 8: signed width of each integer variable.
REQ-004 SHALL have parameter COST_W, default 8: width of failed-constraint count.
REQ-005 SHALL have parameter STEP_W, default 2: integer step magnitude width, step range 1..2^STEP_W.
REQ-006 SHALL have parameter SEED, default 16'hACE1, nonzero: LFSR reset value.
REQ-007 SHALL have ports clk in 1, rising-edge clock; reset in 1, synchronous active-low reset.
REQ-008 SHALL have start in 1 (launch search); max_moves in 16 (move budget); noise_thr in 8 (worse-move acceptance threshold).
REQ-009 SHALL have bool_init in NUM_BOOL and int_init in NUM_INT*INT_W (initial assignment, loaded on start).
REQ-010 SHALL have eval_req out 1, eval_bool out NUM_BOOL, eval_int out NUM_INT*INT_W, eval_ack in 1, eval_cost in COST_W (external constraint-evaluator handshake).
REQ-011 SHALL have busy out 1, done out 1, solved out 1, bool_assign out NUM_BOOL, int_assign out NUM_INT*INT_W, cur_cost out COST_W, move_count out 16.

Function
REQ-012 SHALL use one FSM: IDLE, INIT_EVAL, CHOOSE, PROPOSE, EVAL, DECIDE, DONE.
REQ-013 SHALL, in IDLE or DONE with start=1, load bool_init/int_init into committed assignment, clear move_count and done/solved, enter INIT_EVAL next cycle; start ignored in other states.
REQ-014 SHALL run a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) advancing every cycle while reset=1.
REQ-015 SHALL, in INIT_EVAL/EVAL, hold eval_req=1 with stable eval_bool/eval_int until eval_ack=1 sampled; eval_req=0 the following cycle; eval_ack while eval_req=0 ignored.
REQ-016 SHALL, in INIT_EVAL, latch eval_cost into cur_cost on ack; cost 0 -> DONE with solved=1, else CHOOSE.
REQ-017 SHALL, in CHOOSE, take idx = LFSR low ceil(log2(NUM_BOOL+NUM_INT)) bits; idx >= NUM_BOOL+NUM_INT -> stay in CHOOSE one more cycle (rejection sampling), else latch idx, go PROPOSE.
REQ-018 SHALL, in PROPOSE, for idx<NUM_BOOL invert that boolean; else integer idx-NUM_BOOL gets +/- (LFSR[STEP_W-1:0]+1), sign=LFSR[15], saturating at signed INT_W min/max; proposal held in a copy, committed unchanged.
REQ-019 SHALL present the proposed vector on eval_bool/eval_int during EVAL and latch eval_cost as new_cost on ack.
REQ-020 SHALL, in DECIDE, accept if new_cost <= cur_cost, else accept iff LFSR[7:0] < noise_thr; accept copies proposal to committed and new_cost to cur_cost; reject leaves both.
REQ-021 SHALL increment move_count (saturating at 16'hFFFF) in DECIDE whether accepted or rejected.
REQ-022 SHALL exit DECIDE: cur_cost (post-update) == 0 -> DONE solved=1; else move_count (post-increment) == max_moves -> DONE solved=0; else CHOOSE. Solved has priority on same-cycle coincidence.
REQ-023 SHALL treat max_moves=0 as unlimited moves.
REQ-024 SHALL drive busy=1 in all states except IDLE and DONE; done=1 and solved held constant throughout DONE.
REQ-025 SHALL drive bool_assign/int_assign/cur_cost from committed registers at all times.
REQ-026 SHALL give noise_thr=0 pure greedy descent, noise_thr=255 accepts worse moves with probability 255/256.

Reset
REQ-027 SHALL, on reset=0 at a clock edge, enter IDLE and clear all outputs, assignments, cost, move_count, eval_req to 0 and load LFSR with SEED, including mid-handshake; a pending eval_ack is then ignored.

Verification
REQ-028 SHALL cover: start with evaluator returning 0 on init -> done=1, solved=1, move_count=0, no EVAL requests.
REQ-029 SHALL cover: NUM_BOOL=8, evaluator ack delayed 5 cycles -> eval_req high exactly until ack, vectors stable, eval_req low next cycle.
REQ-030 SHALL cover: noise_thr=0, evaluator always returns higher cost (init 3, proposals 4), max_moves=10 -> assignments unchanged, move_count=10, done=1, solved=0.
REQ-031 SHALL cover: integer at 127 (INT_W=8) proposed +step -> proposal 127; at -128 with -step -> -128.
REQ-032 SHALL cover: evaluator returns 0 on third proposal with max_moves=3 -> solved=1 (priority over budget).
REQ-033 SHALL cover: reset=0 asserted while eval_req=1 -> next cycle IDLE, eval_req=0, busy=0, LFSR=SEED; subsequent start behaves as fresh run.

Source files
------------

// File: rtl/probabilistic_search_engine.sv
// Stochastic local search engine over a mixed boolean / signed-integer
// assignment. Each move flips one boolean or nudges one integer by a small
// random step, asks an external evaluator for the failed-constraint count,
// and keeps the move if it does not increase the cost. A move that does
// increase the cost is still kept with a probability set by noise_thr.

// Saturating signed add/subtract of a small unsigned step to one integer.
module pse_int_step #(
    parameter int INT_W  = 8,
    parameter int STEP_W = 2
) (
    input  logic [INT_W-1:0]  value,
    input  logic [STEP_W:0]   step,
    input  logic              neg,
    output logic [INT_W-1:0]  result
);
    // Wide enough that value +/- step can never wrap before clamping.
    localparam int SUM_W = ((INT_W > STEP_W + 1) ? INT_W : STEP_W + 1) + 2;
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'($signed({1'b0, {(INT_W-1){1'b1}}}));
    localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'($signed({1'b1, {(INT_W-1){1'b0}}}));

    logic signed [SUM_W-1:0] ext;
    logic signed [SUM_W-1:0] mag;
    logic signed [SUM_W-1:0] sum;

    // Extend, apply the signed step, clamp to the INT_W signed range.
    always_comb begin
        ext = SUM_W'($signed(value));
        mag = SUM_W'($signed({1'b0, step}));
        sum = neg ? (ext - mag) : (ext + mag);
        if (sum > MAX_V)
            result = MAX_V[INT_W-1:0];
        else if (sum < MIN_V)
            result = MIN_V[INT_W-1:0];
        else
            result = sum[INT_W-1:0];
    end
endmodule

module probabilistic_search_engine #(
    parameter int          NUM_BOOL = 8,
    parameter int          NUM_INT  = 4,
    parameter int          INT_W    = 8,
    parameter int          COST_W   = 8,
    parameter int          STEP_W   = 2,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [15:0]              max_moves,
    input  logic [7:0]               noise_thr,
    input  logic [NUM_BOOL-1:0]      bool_init,
    input  logic [NUM_INT*INT_W-1:0] int_init,
    output logic                     eval_req,
    output logic [NUM_BOOL-1:0]      eval_bool,
    output logic [NUM_INT*INT_W-1:0] eval_int,
    input  logic                     eval_ack,
    input  logic [COST_W-1:0]        eval_cost,
    output logic                     busy,
    output logic                     done,
    output logic                     solved,
    output logic [NUM_BOOL-1:0]      bool_assign,
    output logic [NUM_INT*INT_W-1:0] int_assign,
    output logic [COST_W-1:0]        cur_cost,
    output logic [15:0]              move_count
);
    localparam int NUM_VARS = NUM_BOOL + NUM_INT;
    localparam int IDX_W    = $clog2(NUM_VARS);
    localparam logic [IDX_W:0] VARS_LIM = (IDX_W+1)'(NUM_VARS);

    typedef enum logic [2:0] {
        IDLE, INIT_EVAL, CHOOSE, PROPOSE, EVAL, DECIDE, DONE
    } state_t;

    state_t state, state_nxt;

    logic [15:0]                   lfsr, lfsr_nxt;
    logic [NUM_BOOL-1:0]           bool_c, bool_p, prop_bool;
    logic [NUM_INT-1:0][INT_W-1:0] int_c, int_p, prop_int, stepped;
    logic [COST_W-1:0]             new_cost, cost_post;
    logic [15:0]                   moves_nxt;
    logic [IDX_W-1:0]              idx_r;
    logic [STEP_W:0]               step_mag;
    logic                          solved_r;
    logic                          accept;
    logic load_init, init_ack, idx_ok, propose, prop_ack, decide, finish, finish_solved;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Step magnitude is 1..2^STEP_W; direction comes from the LFSR MSB.
    assign step_mag = {1'b0, lfsr[STEP_W-1:0]} + (STEP_W+1)'(1);

    for (genvar g = 0; g < NUM_INT; g++) begin : g_int
        pse_int_step #(.INT_W(INT_W), .STEP_W(STEP_W)) u_step (
            .value  (int_c[g]),
            .step   (step_mag),
            .neg    (lfsr[15]),
            .result (stepped[g])
        );
    end

    // Candidate assignment: committed vector with the chosen variable altered.
    always_comb begin
        prop_bool = bool_c;
        prop_int  = int_c;
        for (int i = 0; i < NUM_BOOL; i++)
            if (idx_r == IDX_W'(i)) prop_bool[i] = ~bool_c[i];
        for (int j = 0; j < NUM_INT; j++)
            if (idx_r == IDX_W'(NUM_BOOL + j)) prop_int[j] = stepped[j];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, handshake outputs and datapath strobes.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b1;
        done          = 1'b0;
        eval_req      = 1'b0;
        load_init     = 1'b0;
        init_ack      = 1'b0;
        idx_ok        = 1'b0;
        propose       = 1'b0;
        prop_ack      = 1'b0;
        decide        = 1'b0;
        finish        = 1'b0;
        finish_solved = 1'b0;
        accept    = (new_cost <= cur_cost) || (lfsr[7:0] < noise_thr);
        cost_post = accept ? new_cost : cur_cost;
        moves_nxt = (move_count == 16'hFFFF) ? move_count : move_count + 16'd1;
        case (state)
            IDLE, DONE: begin
                busy = 1'b0;
                done = (state == DONE);
                if (start) begin
                    load_init = 1'b1;
                    state_nxt = INIT_EVAL;
                end
            end
            INIT_EVAL: begin
                eval_req = 1'b1;
                if (eval_ack) begin
                    init_ack = 1'b1;
                    if (eval_cost == '0) begin
                        finish        = 1'b1;
                        finish_solved = 1'b1;
                        state_nxt     = DONE;
                    end else begin
                        state_nxt = CHOOSE;
                    end
                end
            end
            CHOOSE: begin
                // Out-of-range draws are rejected so every variable is equally likely.
                if ({1'b0, lfsr[IDX_W-1:0]} < VARS_LIM) begin
                    idx_ok    = 1'b1;
                    state_nxt = PROPOSE;
                end
            end
            PROPOSE: begin
                propose   = 1'b1;
                state_nxt = EVAL;
            end
            EVAL: begin
                eval_req = 1'b1;
                if (eval_ack) begin
                    prop_ack  = 1'b1;
                    state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                decide = 1'b1;
                // A solution wins over an exhausted budget on the same move.
                if (cost_post == '0) begin
                    finish        = 1'b1;
                    finish_solved = 1'b1;
                    state_nxt     = DONE;
                end else if (max_moves != 16'd0 && moves_nxt == max_moves) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = CHOOSE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: LFSR, committed/proposed assignments, costs and move counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr       <= SEED;
            bool_c     <= '0;
            int_c      <= '0;
            bool_p     <= '0;
            int_p      <= '0;
            cur_cost   <= '0;
            new_cost   <= '0;
            move_count <= '0;
            idx_r      <= '0;
            solved_r   <= 1'b0;
        end else begin
            lfsr <= lfsr_nxt;
            if (load_init) begin
                bool_c     <= bool_init;
                int_c      <= int_init;
                move_count <= '0;
                solved_r   <= 1'b0;
            end
            if (init_ack) cur_cost <= eval_cost;
            if (idx_ok)   idx_r    <= lfsr[IDX_W-1:0];
            if (propose) begin
                bool_p <= prop_bool;
                int_p  <= prop_int;
            end
            if (prop_ack) new_cost <= eval_cost;
            if (decide) begin
                move_count <= moves_nxt;
                if (accept) begin
                    bool_c   <= bool_p;
                    int_c    <= int_p;
                    cur_cost <= new_cost;
                end
            end
            if (finish) solved_r <= finish_solved;
        end
    end

    // The evaluator sees the candidate only while it is being scored.
    assign eval_bool   = (state == EVAL) ? bool_p : bool_c;
    assign eval_int    = (state == EVAL) ? int_p  : int_c;
    assign bool_assign = bool_c;
    assign int_assign  = int_c;
    assign solved      = solved_r;
endmodule
